rotary_bank: RTL and testbench



---
 rtl/rotary_bank_if.sv | 25 ++
 rtl/rotary_bank.sv | 175 +++++++++++++++++
 tb/tb_rotary_bank.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rotary_bank_if.sv
// Front-panel bundle for rotary_bank: encoder phases, buttons, load port, counter outputs.
interface rotary_bank_if #(
    parameter int C = 4,
    parameter int T = 3,
    parameter int W = 4
);
    logic [C-1:0]   zero_i;
    logic [C-1:0]   inc_i;
    logic [C-1:0]   dec_i;
    logic [C*T-1:0] rot_ni;
    logic [C-1:0]   load_i;
    logic [C*W-1:0] load_val_i;
    logic [C*W-1:0] counter_o;
    logic [C-1:0]   step_o;
    logic [C-1:0]   dir_o;

    modport master (
        output zero_i, inc_i, dec_i, rot_ni, load_i, load_val_i,
        input  counter_o, step_o, dir_o
    );
    modport slave (
        input  zero_i, inc_i, dec_i, rot_ni, load_i, load_val_i,
        output counter_o, step_o, dir_o
    );
endinterface

// File: rtl/rotary_bank.sv
// C independent T-phase rotary encoders plus zero/inc/dec buttons driving bounded
// menu counters with parallel load, detent acceleration, step strobe and direction flag.
module rotary_chan #(
    parameter int T        = 3,
    parameter int N        = 12,
    parameter int W        = 4,
    parameter int INIT     = 0,
    parameter int SAT      = 1,
    parameter int DEB      = 240,
    parameter int BTN_DEB  = 5400,
    parameter int ACC_WIN  = 2000,
    parameter int ACC_STEP = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         zero_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic [T-1:0] rot_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] counter_o,
    output logic         step_o,
    output logic         dir_o
);
    localparam int PW = $clog2(DEB + 1);
    localparam int BW = $clog2(BTN_DEB + 1);
    localparam int GW = $clog2(ACC_WIN + 1);
    localparam logic [PW-1:0] P_MAX  = PW'(DEB);
    localparam logic [BW-1:0] B_MAX  = BW'(BTN_DEB);
    localparam logic [GW-1:0] G_MAX  = GW'(ACC_WIN);
    localparam logic [W:0]    TOP    = (W+1)'(N - 1);
    localparam logic [W:0]    MOD    = (W+1)'(N);
    localparam logic [W:0]    FAST   = (W+1)'(ACC_STEP);
    localparam logic [W-1:0]  TOP_W  = W'(N - 1);
    localparam logic [W-1:0]  INIT_V = W'(INIT);

    logic [T-1:0]  s, filt, last;
    logic [PW-1:0] pcnt;
    logic [GW-1:0] gap;
    logic          valid, up_det, dn_det;

    // Phase debounce: filt only follows s after DEB+1 identical samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s    <= '1;
            pcnt <= '0;
            filt <= '1;
        end else begin
            s <= rot_ni;
            if (rot_ni != s)        pcnt <= '0;
            else if (pcnt != P_MAX) pcnt <= pcnt + 1'b1;
            if (pcnt == P_MAX)      filt <= s;
        end
    end

    always_comb begin
        valid  = $onehot(~filt);
        up_det = valid && (filt == {last[0], last[T-1:1]});
        dn_det = valid && (filt == {last[T-2:0], last[T-1]});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last <= '1;
            gap  <= G_MAX;
        end else begin
            if (valid && filt != last) last <= filt;
            if (up_det || dn_det)      gap  <= '0;
            else if (gap != G_MAX)     gap  <= gap + 1'b1;
        end
    end

    logic [2:0]    b_pins, b_s, b_cmd;
    logic [BW-1:0] bcnt;
    logic          b_done, b_fire;

    assign b_pins = {zero_i, inc_i, dec_i};
    assign b_fire = (bcnt == B_MAX) && !b_done;

    // One command per stable hold; b_done blocks repeats until the pattern changes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            b_s    <= '0;
            bcnt   <= '0;
            b_done <= 1'b0;
            b_cmd  <= '0;
        end else begin
            b_s <= b_pins;
            if (b_pins != b_s) begin
                bcnt   <= '0;
                b_done <= 1'b0;
            end else begin
                if (bcnt != B_MAX) bcnt   <= bcnt + 1'b1;
                if (b_fire)        b_done <= 1'b1;
            end
            b_cmd <= b_fire ? b_s : 3'b000;
        end
    end

    logic         fast, up_src, dn_src;
    logic [W:0]   amt, cur, sum;
    logic [W-1:0] nxt, ld_v;

    always_comb begin
        fast   = (gap != G_MAX) && (up_det == dir_o);
        amt    = ((up_det || dn_det) && fast) ? FAST : (W+1)'(1);
        up_src = up_det | b_cmd[1];
        dn_src = dn_det | b_cmd[0];
        cur    = {1'b0, counter_o};
        sum    = cur + amt;
        if (up_src) begin
            if (sum > TOP) nxt = (SAT != 0) ? TOP_W : W'(sum - MOD);
            else           nxt = sum[W-1:0];
        end else begin
            if (cur < amt) nxt = (SAT != 0) ? '0 : W'(cur + MOD - amt);
            else           nxt = W'(cur - amt);
        end
        ld_v = ({1'b0, load_val_i} > TOP) ? TOP_W : load_val_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            counter_o <= INIT_V;
            step_o    <= 1'b0;
            dir_o     <= 1'b0;
        end else begin
            step_o <= 1'b0;
            if (load_i)        counter_o <= ld_v;
            else if (b_cmd[2]) counter_o <= INIT_V;
            else if (up_src != dn_src) begin
                step_o    <= 1'b1;
                dir_o     <= up_src;
                counter_o <= nxt;
            end
        end
    end
endmodule

module rotary_bank #(
    parameter int C        = 4,
    parameter int T        = 3,
    parameter int N        = 12,
    parameter int INIT     = 0,
    parameter int SAT      = 1,
    parameter int DEB      = 240,
    parameter int BTN_DEB  = 5400,
    parameter int ACC_WIN  = 2000,
    parameter int ACC_STEP = 4
) (
    input logic         clk_i,
    input logic         rst_i,
    rotary_bank_if.slave bus
);
    localparam int W = $clog2(N);

    for (genvar c = 0; c < C; c++) begin : g_chan
        rotary_chan #(
            .T(T), .N(N), .W(W), .INIT(INIT), .SAT(SAT), .DEB(DEB),
            .BTN_DEB(BTN_DEB), .ACC_WIN(ACC_WIN), .ACC_STEP(ACC_STEP)
        ) u_chan (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .zero_i     (bus.zero_i[c]),
            .inc_i      (bus.inc_i[c]),
            .dec_i      (bus.dec_i[c]),
            .rot_ni     (bus.rot_ni[c*T +: T]),
            .load_i     (bus.load_i[c]),
            .load_val_i (bus.load_val_i[c*W +: W]),
            .counter_o  (bus.counter_o[c*W +: W]),
            .step_o     (bus.step_o[c]),
            .dir_o      (bus.dir_o[c])
        );
    end
endmodule

// File: tb/tb_rotary_bank.sv
// Bench for rotary_bank: saturating and wrapping instances share stimulus and are
// checked every cycle against an event-level model of detents, buttons and loads.
module tb_rotary_bank;
    localparam int C = 2, T = 3, N = 12, W = 4, INIT = 0;
    localparam int DEB = 4, BTN_DEB = 8, ACC_WIN = 50, ACC_STEP = 4;
    localparam int EV_NONE = 0, EV_ROT = 1, EV_BTN = 2, EV_LOAD = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [C-1:0]   zero = '0, inc = '0, dec = '0, load = '0;
    logic [C*T-1:0] rot = '1;
    logic [C*W-1:0] load_val = '0;
    int             cyc = 0;
    int             n_chk = 0, n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rotary_bank_if #(.C(C), .T(T), .W(W)) bus_s ();
    rotary_bank_if #(.C(C), .T(T), .W(W)) bus_w ();

    assign bus_s.zero_i = zero;     assign bus_w.zero_i = zero;
    assign bus_s.inc_i = inc;       assign bus_w.inc_i = inc;
    assign bus_s.dec_i = dec;       assign bus_w.dec_i = dec;
    assign bus_s.rot_ni = rot;      assign bus_w.rot_ni = rot;
    assign bus_s.load_i = load;     assign bus_w.load_i = load;
    assign bus_s.load_val_i = load_val;
    assign bus_w.load_val_i = load_val;

    rotary_bank #(.C(C), .T(T), .N(N), .INIT(INIT), .SAT(1), .DEB(DEB), .BTN_DEB(BTN_DEB),
                  .ACC_WIN(ACC_WIN), .ACC_STEP(ACC_STEP))
        u_dut_s (.clk_i(clk), .rst_i(rst), .bus(bus_s));
    rotary_bank #(.C(C), .T(T), .N(N), .INIT(INIT), .SAT(0), .DEB(DEB), .BTN_DEB(BTN_DEB),
                  .ACC_WIN(ACC_WIN), .ACC_STEP(ACC_STEP))
        u_dut_w (.clk_i(clk), .rst_i(rst), .bus(bus_w));

    // Model: variant 0 saturates, variant 1 wraps. m_last is the low-phase index (-1 = none).
    int         m_cnt [2][C];
    int         m_dir [2][C];
    bit         m_step[2][C];
    int         m_last[C];
    int         m_det [C];
    int         ev_kind = EV_NONE, ev_cyc = 0, ev_ch = 0, ev_ldv = 0;
    logic [T-1:0] ev_pat = '1;
    logic [2:0] ev_btn = '0;
    bit         ev_ld = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int low_idx(input logic [T-1:0] p);
        int n = 0, idx = -1;
        for (int i = 0; i < T; i++) if (!p[i]) begin n++; idx = i; end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic logic [T-1:0] pat(input int idx);
        logic [T-1:0] p = '1;
        p[idx] = 1'b0;
        return p;
    endfunction

    task automatic m_move(input int v, input int ch, input int up, input int a);
        if (up != 0) begin
            if (m_cnt[v][ch] + a > N - 1) m_cnt[v][ch] = (v == 0) ? N - 1 : m_cnt[v][ch] + a - N;
            else m_cnt[v][ch] += a;
        end else begin
            if (m_cnt[v][ch] < a) m_cnt[v][ch] = (v == 0) ? 0 : m_cnt[v][ch] + N - a;
            else m_cnt[v][ch] -= a;
        end
        m_dir[v][ch]  = up;
        m_step[v][ch] = 1'b1;
    endtask

    task automatic apply_ev();
        int ch, idx, dirn;
        bit fast;
        ch = ev_ch;
        if (ev_kind == EV_ROT) begin
            idx  = low_idx(ev_pat);
            dirn = -1;
            if (idx >= 0) begin
                if (m_last[ch] >= 0 && idx == (m_last[ch] + T - 1) % T) dirn = 1;
                else if (m_last[ch] >= 0 && idx == (m_last[ch] + 1) % T) dirn = 0;
                if (dirn >= 0) begin
                    for (int v = 0; v < 2; v++) if (!ev_ld) begin
                        fast = (cyc - m_det[ch] <= ACC_WIN) && (m_dir[v][ch] == dirn);
                        m_move(v, ch, dirn, fast ? ACC_STEP : 1);
                    end
                    m_det[ch] = cyc;
                end
                m_last[ch] = idx;
            end
        end else if (ev_kind == EV_BTN) begin
            for (int v = 0; v < 2; v++) begin
                if (ev_btn[2]) m_cnt[v][ch] = INIT;
                else if (ev_btn[1] != ev_btn[0]) m_move(v, ch, int'(ev_btn[1]), 1);
            end
        end
        if (ev_kind == EV_LOAD || (ev_kind == EV_ROT && ev_ld))
            for (int v = 0; v < 2; v++) m_cnt[v][ch] = (ev_ldv > N - 1) ? N - 1 : ev_ldv;
        ev_kind = EV_NONE;
    endtask

    task automatic tick();
        logic [C*W-1:0] cs;
        logic [C-1:0]   st, dr;
        @(posedge clk);
        #1;
        for (int v = 0; v < 2; v++) for (int ch = 0; ch < C; ch++) m_step[v][ch] = 1'b0;
        if (ev_kind != EV_NONE && cyc == ev_cyc) apply_ev();
        for (int v = 0; v < 2; v++) begin
            cs = (v == 0) ? bus_s.counter_o : bus_w.counter_o;
            st = (v == 0) ? bus_s.step_o : bus_w.step_o;
            dr = (v == 0) ? bus_s.dir_o : bus_w.dir_o;
            for (int ch = 0; ch < C; ch++) begin
                chk($sformatf("counter v%0d ch%0d", v, ch), int'(cs[ch*W +: W]), m_cnt[v][ch]);
                chk($sformatf("step v%0d ch%0d", v, ch), int'(st[ch]), int'(m_step[v][ch]));
                chk($sformatf("dir v%0d ch%0d", v, ch), int'(dr[ch]), m_dir[v][ch]);
            end
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        ev_kind = EV_NONE;
        for (int v = 0; v < 2; v++) for (int ch = 0; ch < C; ch++) begin
            m_cnt[v][ch] = INIT;
            m_dir[v][ch] = 0;
        end
        // After reset the current pins settle into filt without producing a detent.
        for (int ch = 0; ch < C; ch++) begin
            m_last[ch] = low_idx(rot[ch*T +: T]);
            m_det[ch]  = -100000;
        end
        tick();
        tick();
        rst = 1'b0;
        repeat (DEB + 6) tick();
    endtask

    task automatic rot_op(input int ch, input logic [T-1:0] p, input int hold,
                          input bit ld, input int ldv);
        int d;
        // Keep detent spacing clear of the acceleration window edge.
        d = cyc + DEB + 3 - m_det[ch];
        if (d >= ACC_WIN - 3 && d <= ACC_WIN + 3) repeat (8) tick();
        rot[ch*T +: T] = p;
        ev_kind = EV_ROT; ev_ch = ch; ev_pat = p; ev_ld = ld; ev_ldv = ldv;
        ev_cyc  = cyc + DEB + 3;
        for (int k = 1; k <= hold; k++) begin
            tick();
            if (ld && k == DEB + 2) begin
                load[ch] = 1'b1;
                load_val[ch*W +: W] = W'(ldv);
            end else if (k == DEB + 3) begin
                load[ch] = 1'b0;
            end
        end
    endtask

    task automatic glitch_op(input int ch, input int g);
        logic [T-1:0] old;
        int idx;
        old = rot[ch*T +: T];
        idx = low_idx(old);
        rot[ch*T +: T] = (idx >= 0) ? pat((idx + 1) % T) : pat(0);
        repeat (g) tick();
        rot[ch*T +: T] = old;
        repeat (DEB + 6) tick();
    endtask

    task automatic btn_op(input int ch, input logic [2:0] b, input int hold);
        zero[ch] = b[2]; inc[ch] = b[1]; dec[ch] = b[0];
        ev_kind = EV_BTN; ev_ch = ch; ev_btn = b; ev_ld = 1'b0;
        ev_cyc  = cyc + BTN_DEB + 3;
        repeat (hold) tick();
        zero[ch] = 1'b0; inc[ch] = 1'b0; dec[ch] = 1'b0;
        repeat (BTN_DEB + 4) tick();
    endtask

    task automatic load_op(input int ch, input int val);
        load[ch] = 1'b1;
        load_val[ch*W +: W] = W'(val);
        ev_kind = EV_LOAD; ev_ch = ch; ev_ldv = val; ev_cyc = cyc + 1;
        tick();
        load[ch] = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [T-1:0] p;
        do_reset();
        // Two up detents on ch0 after the first valid state, slow spacing.
        rot_op(0, pat(2), 200, 1'b0, 0);
        rot_op(0, pat(1), 200, 1'b0, 0);
        rot_op(0, pat(0), 200, 1'b0, 0);
        // Three down detents: saturates at 0 / wraps to N-1.
        rot_op(0, pat(1), 200, 1'b0, 0);
        rot_op(0, pat(2), 200, 1'b0, 0);
        rot_op(0, pat(0), 200, 1'b0, 0);
        // Fast up detents then a short glitch.
        rot_op(0, pat(2), 20, 1'b0, 0);
        rot_op(0, pat(1), 20, 1'b0, 0);
        rot_op(0, pat(0), 20, 1'b0, 0);
        rot_op(0, pat(2), 20, 1'b0, 0);
        glitch_op(0, DEB);
        glitch_op(0, 1);
        // Buttons: inc hold, zero, inc+dec together, dec.
        btn_op(0, 3'b010, 100);
        btn_op(0, 3'b100, 30);
        btn_op(0, 3'b011, 30);
        btn_op(0, 3'b001, 30);
        // Load on ch1 colliding with a detent, then an out-of-range load.
        rot_op(1, pat(2), 60, 1'b0, 0);
        rot_op(1, pat(1), 60, 1'b1, 7);
        load_op(1, 15);
        rot_op(1, pat(0), 60, 1'b0, 0);
        // Idle and invalid states between detents.
        rot_op(0, '1, 60, 1'b0, 0);
        rot_op(0, pat(1), 60, 1'b0, 0);
        p = 3'b000;
        rot_op(0, p, 60, 1'b0, 0);
        p = 3'b100;
        rot_op(0, p, 60, 1'b0, 0);
        rot_op(0, pat(0), 60, 1'b0, 0);
        // Reset in the middle of a phase debounce.
        rot[0 +: T] = pat(2);
        tick();
        tick();
        do_reset();
        repeat (30) tick();
        // Randomized mix.
        for (int i = 0; i < 150; i++) begin
            int ch, op, hold;
            ch   = $urandom_range(0, C - 1);
            op   = $urandom_range(0, 9);
            hold = ($urandom_range(0, 1) != 0) ? $urandom_range(10, 35) : $urandom_range(60, 150);
            if (op < 6) begin
                if ($urandom_range(0, 3) != 0) p = pat($urandom_range(0, T - 1));
                else p = T'($urandom);
                rot_op(ch, p, hold, ($urandom_range(0, 7) == 0), $urandom_range(0, 15));
            end else if (op < 8) begin
                btn_op(ch, 3'($urandom_range(0, 7)), $urandom_range(BTN_DEB + 3, BTN_DEB + 30));
            end else if (op == 8) begin
                load_op(ch, $urandom_range(0, 15));
            end else begin
                glitch_op(ch, $urandom_range(1, DEB));
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
